// File: rtl/slave_pkg.sv
// Shared types for the bit-serial bus slave port.
// Default widths, FSM state encoding and the burst-beat counter type.
package slave_pkg;

    localparam int ADDR_WIDTH_D     = 12;
    localparam int BURST_WIDTH_D    = 13;
    localparam int DATA_WIDTH_D     = 8;
    localparam int MEM_ADDR_WIDTH_D = 11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        BURST,
        WDATA,
        WSTORE,
        RFETCH,
        RDATA,
        DONE
    } slave_state_t;

    typedef logic [BURST_WIDTH_D-1:0] beat_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/slave_port_if.sv
// Serial bus link between a master port and one slave port.
// The master drives bits and acks; the slave returns ready/valid/done.
interface slave_port_if;

    logic master_valid;
    logic write_en;
    logic read_en;
    logic rx_address;
    logic rx_burst;
    logic rx_data;
    logic slave_ready;
    logic slave_valid;
    logic tx_data;
    logic rx_done;
    logic slave_err;

    modport master (
        output master_valid,
        output write_en,
        output read_en,
        output rx_address,
        output rx_burst,
        output rx_data,
        input  slave_ready,
        input  slave_valid,
        input  tx_data,
        input  rx_done,
        input  slave_err
    );

    modport slave (
        input  master_valid,
        input  write_en,
        input  read_en,
        input  rx_address,
        input  rx_burst,
        input  rx_data,
        output slave_ready,
        output slave_valid,
        output tx_data,
        output rx_done,
        output slave_err
    );

endinterface

// File: rtl/slave_bram.sv
// Single-port synchronous RAM backing one slave.
// Read data is registered: valid the cycle after the address is presented.
module slave_bram #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus slave: shifts in address/burst/data LSB-first, serves reads.
// Define SLAVE_ADDR_CHECK_EN to reject addresses with bits above the memory range.
module slave_port
    import slave_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_D,
    parameter int BURST_WIDTH    = BURST_WIDTH_D,
    parameter int DATA_WIDTH     = DATA_WIDTH_D,
    parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_D
) (
    input logic         clk,
    input logic         reset,
    slave_port_if.slave bus
);

    localparam int CNT_W =
        $clog2(max3(ADDR_WIDTH, BURST_WIDTH, DATA_WIDTH) + 1);

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [BURST_WIDTH-1:0] beats_t;
    typedef logic [DATA_WIDTH-1:0]  data_t;

    localparam addr_t LO_MASK = addr_t'({MEM_ADDR_WIDTH{1'b1}});

    slave_state_t state_q, state_d;
    logic         wr_q, wr_d;
    logic         bad_q, bad_d;
    addr_t        addr_q, addr_d;
    beats_t       beats_q, beats_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    data_t        shreg_q, shreg_d;

    logic ready_q, ready_d;
    logic valid_q, valid_d;
    logic tx_q, tx_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic                      ram_we;
    addr_t                     ram_sel;
    logic [MEM_ADDR_WIDTH-1:0] ram_addr;
    data_t                     ram_rdata;
    addr_t                     addr_inc;
    logic                      cnt_last;

    // Only the in-memory bits wrap; upper bits ride along for checking.
    assign addr_inc = (addr_q & ~LO_MASK)
                    | ((addr_q + addr_t'(1)) & LO_MASK);

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        bad_d    = bad_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        err_d    = 1'b0;
        ram_we   = 1'b0;
        cnt_last = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.master_valid && (bus.write_en ^ bus.read_en)) begin
                    wr_d    = bus.write_en;
                    bad_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.master_valid) begin
                    addr_d   = {bus.rx_address, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d    = cnt_q + 1'b1;
                    cnt_last = (cnt_q == CNT_W'(ADDR_WIDTH - 1));
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = BURST;
`ifdef SLAVE_ADDR_CHECK_EN
                        bad_d = |(addr_d & ~LO_MASK);
                        err_d = bad_d;
`endif
                    end
                end
            end
            BURST: begin
                if (bus.master_valid) begin
                    beats_d  = {bus.rx_burst, beats_q[BURST_WIDTH-1:1]};
                    cnt_d    = cnt_q + 1'b1;
                    cnt_last = (cnt_q == CNT_W'(BURST_WIDTH - 1));
                    if (cnt_last) begin
                        cnt_d = '0;
                        if (beats_d == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = wr_q ? WDATA : RFETCH;
                        end
                    end
                end
            end
            WDATA: begin
                if (bus.master_valid) begin
                    shreg_d  = {bus.rx_data, shreg_q[DATA_WIDTH-1:1]};
                    cnt_d    = cnt_q + 1'b1;
                    cnt_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = WSTORE;
                    end
                end
            end
            WSTORE: begin
                ram_we  = !bad_q;
                addr_d  = addr_inc;
                beats_d = beats_q - 1'b1;
                state_d = (beats_q == beats_t'(1)) ? DONE : WDATA;
            end
            RFETCH: begin
                shreg_d = bad_q ? '1 : ram_rdata;
                state_d = RDATA;
            end
            RDATA: begin
                if (bus.master_valid) begin
                    shreg_d  = shreg_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    cnt_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));
                    if (cnt_last) begin
                        cnt_d   = '0;
                        addr_d  = addr_inc;
                        beats_d = beats_q - 1'b1;
                        state_d = (beats_q == beats_t'(1)) ? DONE : RFETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == ADDR)
               || (state_d == BURST) || (state_d == WDATA);
        valid_d = (state_d == RDATA);
        tx_d    = valid_d & shreg_d[0];
        done_d  = (state_d == DONE);
    end

    // The read port looks one cycle ahead so rdata is ready in RFETCH.
    assign ram_sel  = (state_q == WSTORE) ? addr_q : addr_d;
    assign ram_addr = ram_sel[MEM_ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    slave_bram #(
        .AW(MEM_ADDR_WIDTH),
        .DW(DATA_WIDTH)
    ) u_bram (
        .clk  (clk),
        .we   (ram_we && !reset),
        .addr (ram_addr),
        .wdata(shreg_q),
        .rdata(ram_rdata)
    );

    assign bus.slave_ready = ready_q;
    assign bus.slave_valid = valid_q;
    assign bus.tx_data     = tx_q;
    assign bus.rx_done     = done_q;
    assign bus.slave_err   = err_q;

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: driver pushes expected events,
// a negedge monitor pops them as read bits, done and error pulses appear.
module tb_slave_port;
    import slave_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    slave_port_if bus();

    slave_port dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef enum int {EV_BIT, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t k;
        logic     v;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc_cnt = 0;

    always @(posedge clk) cyc_cnt++;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void push(ev_kind_t k, logic v);
        ev_t e;
        e.k = k;
        e.v = v;
        exp_q.push_back(e);
    endfunction

    function automatic void pop(ev_kind_t k, logic v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d want none @%0t",
                     k, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.k);
            if (k == EV_BIT && e.k == EV_BIT) chk("tx_bit", v, e.v);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.slave_err) pop(EV_ERR, 1'b0);
            if (bus.slave_valid && bus.master_valid) pop(EV_BIT, bus.tx_data);
            if (bus.rx_done) pop(EV_DONE, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input int n);
        bus.master_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.slave_ready && t < 50) begin
            bus.master_valid = 1'b0;
            tick();
            t++;
        end
        if (t == 50) chk("ready_timeout", 32'(t), 0);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.slave_valid && t < 50) begin
            bus.master_valid = 1'b0;
            tick();
            t++;
        end
        if (t == 50) chk("valid_timeout", 32'(t), 0);
    endtask

    // sel: 0 address, 1 burst, 2 data
    task automatic send(input int sel, input logic b);
        wait_ready();
        bus.rx_address   = (sel == 0) ? b : 1'b0;
        bus.rx_burst     = (sel == 1) ? b : 1'b0;
        bus.rx_data      = (sel == 2) ? b : 1'b0;
        bus.master_valid = 1'b1;
        tick();
    endtask

    task automatic xact(input bit wr, input logic [11:0] addr,
                        input beat_t n, input logic [7:0] d [4],
                        input int stall_a, input int stall_r,
                        input int abort_bit, input bit lat);
        int   c0;
        int   t;
        logic [7:0] byt;
`ifdef SLAVE_ADDR_CHECK_EN
        if (addr[11]) push(EV_ERR, 1'b0);
`endif
        if (!wr) begin
            for (int b = 0; b < int'(n); b++) begin
                byt = d[b];
                for (int i = 0; i < 8; i++) push(EV_BIT, byt[i]);
            end
            push(EV_DONE, 1'b0);
        end
        bus.master_valid = 1'b1;
        bus.write_en     = wr;
        bus.read_en      = !wr;
        c0 = cyc_cnt;
        tick();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == stall_a) stall(5);
            send(0, addr[i]);
        end
        for (int i = 0; i < 13; i++) send(1, n[i]);
        if (wr) begin
            for (int b = 0; b < int'(n); b++) begin
                byt = d[b];
                for (int i = 0; i < 8; i++) begin
                    if (b == 0 && i == abort_bit) begin
                        reset            = 1'b1;
                        bus.master_valid = 1'b0;
                        tick();
                        chk("abort_ready", bus.slave_ready, 1);
                        chk("abort_valid", bus.slave_valid, 0);
                        reset = 1'b0;
                        return;
                    end
                    send(2, byt[i]);
                end
            end
            push(EV_DONE, 1'b0);
        end else begin
            for (int b = 0; b < int'(n); b++) begin
                for (int i = 0; i < 8; i++) begin
                    if (b == 0 && i == stall_r) stall(5);
                    wait_valid();
                    bus.master_valid = 1'b1;
                    tick();
                end
            end
        end
        bus.master_valid = 1'b0;
        t = 0;
        while (!bus.rx_done && t < 100) begin
            tick();
            t++;
        end
        if (t == 100) chk("done_timeout", 32'(t), 0);
        if (lat) chk("latency", 32'(cyc_cnt - c0), 32'(1 + 12 + 13 + int'(n) * 9));
        tick();
    endtask

    initial begin
        reset            = 1'b1;
        bus.master_valid = 1'b0;
        bus.write_en     = 1'b0;
        bus.read_en      = 1'b0;
        bus.rx_address   = 1'b0;
        bus.rx_burst     = 1'b0;
        bus.rx_data      = 1'b0;
        repeat (3) tick();
        chk("rst_ready", bus.slave_ready, 1);
        chk("rst_valid", bus.slave_valid, 0);
        chk("rst_tx", bus.tx_data, 0);
        chk("rst_done", bus.rx_done, 0);
        chk("rst_err", bus.slave_err, 0);
        reset = 1'b0;
        tick();

        xact(1, 12'h005, 1, '{8'hA5, 0, 0, 0}, -1, -1, -1, 1);
        xact(0, 12'h005, 1, '{8'hA5, 0, 0, 0}, -1, -1, -1, 1);

        xact(1, 12'h7FF, 3, '{8'h11, 8'h22, 8'h33, 0}, -1, -1, -1, 1);
        xact(0, 12'h7FF, 3, '{8'h11, 8'h22, 8'h33, 0}, -1, -1, -1, 1);
        xact(0, 12'h000, 1, '{8'h22, 0, 0, 0}, -1, -1, -1, 0);
        xact(0, 12'h001, 1, '{8'h33, 0, 0, 0}, -1, -1, -1, 0);

        xact(1, 12'h123, 2, '{8'hC3, 8'h5E, 0, 0}, 5, -1, -1, 0);
        xact(0, 12'h123, 2, '{8'hC3, 8'h5E, 0, 0}, 7, 3, -1, 0);

        bus.master_valid = 1'b1;
        bus.write_en     = 1'b1;
        bus.read_en      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("both_en_ready", bus.slave_ready, 1);
        end
        bus.master_valid = 1'b0;
        bus.write_en     = 1'b0;
        bus.read_en      = 1'b0;
        tick();
        xact(0, 12'h124, 1, '{8'h5E, 0, 0, 0}, -1, -1, -1, 0);

        xact(1, 12'h005, 0, '{0, 0, 0, 0}, -1, -1, -1, 1);
        xact(0, 12'h005, 1, '{8'hA5, 0, 0, 0}, -1, -1, -1, 0);

        xact(1, 12'h005, 1, '{8'hFF, 0, 0, 0}, -1, -1, 4, 0);
        tick();
        xact(0, 12'h005, 1, '{8'hA5, 0, 0, 0}, -1, -1, -1, 0);

`ifdef SLAVE_ADDR_CHECK_EN
        xact(1, 12'h800, 1, '{8'h5A, 0, 0, 0}, -1, -1, -1, 0);
        xact(0, 12'h000, 1, '{8'h22, 0, 0, 0}, -1, -1, -1, 0);
        xact(0, 12'h800, 1, '{8'hFF, 0, 0, 0}, -1, -1, -1, 0);
`else
        xact(1, 12'h805, 1, '{8'h3C, 0, 0, 0}, -1, -1, -1, 0);
        xact(0, 12'h005, 1, '{8'h3C, 0, 0, 0}, -1, -1, -1, 0);
`endif

        repeat (4) tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
